// File: rtl/d_alu_decoder_pkg.sv
// d_alu_decoder_pkg: shared codes for the integer-ALU decode slice.
//   - grand_op / sub-op codes consumed by the execute-stage ALU
//   - opcode match constants for each instruction format
//   - alu_dec_t: the decoded bundle carried from decode to issue
package d_alu_decoder_pkg;

    // Grand-op classes. Zero is the ALU default (result 0).
    localparam logic [2:0] GRAND_OP_NONE = 3'd0;
    localparam logic [2:0] GRAND_OP_BW   = 3'd1;
    localparam logic [2:0] GRAND_OP_LI   = 3'd2;
    localparam logic [2:0] GRAND_OP_INT  = 3'd3;
    localparam logic [2:0] GRAND_OP_SFT  = 3'd4;
    localparam logic [2:0] GRAND_OP_COM  = 3'd5;

    localparam logic [2:0] BW_AND  = 3'd0;
    localparam logic [2:0] BW_OR   = 3'd1;
    localparam logic [2:0] BW_NOR  = 3'd2;
    localparam logic [2:0] BW_XOR  = 3'd3;
    localparam logic [2:0] BW_ANDN = 3'd4;
    localparam logic [2:0] BW_ORN  = 3'd5;

    localparam logic [2:0] LI_LUI     = 3'd0;
    localparam logic [2:0] LI_PCADDUI = 3'd1;

    localparam logic [2:0] INT_ADD  = 3'd0;
    localparam logic [2:0] INT_SUB  = 3'd1;
    localparam logic [2:0] INT_SLT  = 3'd2;
    localparam logic [2:0] INT_SLTU = 3'd3;

    localparam logic [2:0] SFT_SLL = 3'd0;
    localparam logic [2:0] SFT_SRL = 3'd1;
    localparam logic [2:0] SFT_SRA = 3'd2;

    localparam logic [2:0] COM_EQ  = 3'd0;
    localparam logic [2:0] COM_NE  = 3'd1;
    localparam logic [2:0] COM_LT  = 3'd2;
    localparam logic [2:0] COM_GE  = 3'd3;
    localparam logic [2:0] COM_LTU = 3'd4;
    localparam logic [2:0] COM_GEU = 3'd5;

    // 3R and shift-immediate, keyed on inst[31:15]
    localparam logic [16:0] OPC_ADD_W  = 17'h00020;
    localparam logic [16:0] OPC_SUB_W  = 17'h00022;
    localparam logic [16:0] OPC_SLT    = 17'h00024;
    localparam logic [16:0] OPC_SLTU   = 17'h00025;
    localparam logic [16:0] OPC_NOR    = 17'h00028;
    localparam logic [16:0] OPC_AND    = 17'h00029;
    localparam logic [16:0] OPC_OR     = 17'h0002A;
    localparam logic [16:0] OPC_XOR    = 17'h0002B;
    localparam logic [16:0] OPC_ORN    = 17'h0002C;
    localparam logic [16:0] OPC_ANDN   = 17'h0002D;
    localparam logic [16:0] OPC_SLL_W  = 17'h0002E;
    localparam logic [16:0] OPC_SRL_W  = 17'h0002F;
    localparam logic [16:0] OPC_SRA_W  = 17'h00030;
    localparam logic [16:0] OPC_SLLI_W = 17'h00081;
    localparam logic [16:0] OPC_SRLI_W = 17'h00089;
    localparam logic [16:0] OPC_SRAI_W = 17'h00091;

    // 2RI12, keyed on inst[31:22]
    localparam logic [9:0] OPC_SLTI   = 10'h008;
    localparam logic [9:0] OPC_SLTUI  = 10'h009;
    localparam logic [9:0] OPC_ADDI_W = 10'h00A;
    localparam logic [9:0] OPC_ANDI   = 10'h00D;
    localparam logic [9:0] OPC_ORI    = 10'h00E;
    localparam logic [9:0] OPC_XORI   = 10'h00F;

    // 1RI20, keyed on inst[31:25]
    localparam logic [6:0] OPC_LU12I_W   = 7'h0A;
    localparam logic [6:0] OPC_PCADDU12I = 7'h0E;

    // Branches, keyed on inst[31:26]
    localparam logic [5:0] OPC_BEQ  = 6'h16;
    localparam logic [5:0] OPC_BNE  = 6'h17;
    localparam logic [5:0] OPC_BLT  = 6'h18;
    localparam logic [5:0] OPC_BGE  = 6'h19;
    localparam logic [5:0] OPC_BLTU = 6'h1A;
    localparam logic [5:0] OPC_BGEU = 6'h1B;

    typedef struct packed {
        logic [2:0]  grand_op;
        logic [2:0]  op;
        logic [4:0]  rj;
        logic [4:0]  rk;
        logic [4:0]  rd;
        logic        wen;
        logic        use_imm;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } alu_dec_t;

endpackage

// File: rtl/d_alu_dec_comb.sv
// d_alu_dec_comb: purely combinational LoongArch32 integer-ALU decoder.
//   inst : 32-bit instruction word
//   pc   : instruction PC, copied into the bundle
//   dec  : decoded alu_dec_t bundle; words that match no opcode come out
//          as grand_op 0 with wen/use_imm cleared and illegal set
module d_alu_dec_comb
    import d_alu_decoder_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output alu_dec_t    dec
);

    logic legal;
    logic writes;

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        dec      = '0;
        legal    = 1'b1;
        writes   = 1'b1;
        dec.rj   = inst[9:5];
        dec.rk   = inst[14:10];
        dec.rd   = inst[4:0];
        dec.pc   = pc;

        case (inst[31:15])
            OPC_ADD_W:  begin dec.grand_op = GRAND_OP_INT; dec.op = INT_ADD;  end
            OPC_SUB_W:  begin dec.grand_op = GRAND_OP_INT; dec.op = INT_SUB;  end
            OPC_SLT:    begin dec.grand_op = GRAND_OP_INT; dec.op = INT_SLT;  end
            OPC_SLTU:   begin dec.grand_op = GRAND_OP_INT; dec.op = INT_SLTU; end
            OPC_NOR:    begin dec.grand_op = GRAND_OP_BW;  dec.op = BW_NOR;   end
            OPC_AND:    begin dec.grand_op = GRAND_OP_BW;  dec.op = BW_AND;   end
            OPC_OR:     begin dec.grand_op = GRAND_OP_BW;  dec.op = BW_OR;    end
            OPC_XOR:    begin dec.grand_op = GRAND_OP_BW;  dec.op = BW_XOR;   end
            OPC_ORN:    begin dec.grand_op = GRAND_OP_BW;  dec.op = BW_ORN;   end
            OPC_ANDN:   begin dec.grand_op = GRAND_OP_BW;  dec.op = BW_ANDN;  end
            OPC_SLL_W:  begin dec.grand_op = GRAND_OP_SFT; dec.op = SFT_SLL;  end
            OPC_SRL_W:  begin dec.grand_op = GRAND_OP_SFT; dec.op = SFT_SRL;  end
            OPC_SRA_W:  begin dec.grand_op = GRAND_OP_SFT; dec.op = SFT_SRA;  end
            OPC_SLLI_W, OPC_SRLI_W, OPC_SRAI_W: begin
                dec.grand_op = GRAND_OP_SFT;
                dec.op       = (inst[31:15] == OPC_SLLI_W) ? SFT_SLL :
                               (inst[31:15] == OPC_SRLI_W) ? SFT_SRL : SFT_SRA;
                dec.use_imm  = 1'b1;
                dec.imm      = {27'b0, inst[14:10]};
            end
            default: begin
                case (inst[31:22])
                    OPC_SLTI, OPC_SLTUI, OPC_ADDI_W: begin
                        dec.grand_op = GRAND_OP_INT;
                        dec.op       = (inst[31:22] == OPC_SLTI)  ? INT_SLT  :
                                       (inst[31:22] == OPC_SLTUI) ? INT_SLTU : INT_ADD;
                        dec.use_imm  = 1'b1;
                        dec.imm      = {{20{inst[21]}}, inst[21:10]};
                    end
                    OPC_ANDI, OPC_ORI, OPC_XORI: begin
                        dec.grand_op = GRAND_OP_BW;
                        dec.op       = (inst[31:22] == OPC_ANDI) ? BW_AND :
                                       (inst[31:22] == OPC_ORI)  ? BW_OR  : BW_XOR;
                        dec.use_imm  = 1'b1;
                        dec.imm      = {20'b0, inst[21:10]};
                    end
                    default: begin
                        case (inst[31:25])
                            OPC_LU12I_W, OPC_PCADDU12I: begin
                                // Raw 20-bit field; the ALU applies the <<12.
                                dec.grand_op = GRAND_OP_LI;
                                dec.op       = (inst[31:25] == OPC_LU12I_W) ? LI_LUI : LI_PCADDUI;
                                dec.use_imm  = 1'b1;
                                dec.imm      = {12'b0, inst[24:5]};
                            end
                            default: begin
                                case (inst[31:26])
                                    OPC_BEQ, OPC_BNE, OPC_BLT, OPC_BGE, OPC_BLTU, OPC_BGEU: begin
                                        // Branches compare rj against the register in the rd slot.
                                        dec.grand_op = GRAND_OP_COM;
                                        dec.op       = 3'(inst[31:26] - OPC_BEQ);
                                        dec.rk       = inst[4:0];
                                        dec.imm      = {{14{inst[25]}}, inst[25:10], 2'b00};
                                        writes       = 1'b0;
                                    end
                                    default: legal = 1'b0;
                                endcase
                            end
                        endcase
                    end
                endcase
            end
        endcase

        dec.wen     = legal & writes & (inst[4:0] != 5'd0);
        dec.illegal = ~legal;
    end

endmodule

// File: rtl/d_alu_decoder.sv
// d_alu_decoder: registered decode stage for integer-ALU instructions with a
// 2-entry output skid buffer (head register + one skid entry), so in_ready_o
// is a flop output.
//   clk, rst_n              : clock, asynchronous active-low reset
//   flush_i                 : kills every held entry, highest priority
//   in_valid_i/in_ready_o   : instruction handshake (inst_i, pc_i)
//   out_valid_o/out_ready_i : decoded bundle handshake
//   grand_op_o .. pc_o      : decoded bundle held in the head register
//   illegal_o               : undecodable word flag, present only when
//                             D_DECODE_ILLEGAL_FLAG_EN is defined
module d_alu_decoder
    import d_alu_decoder_pkg::*;
#(
    parameter int SKID_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [2:0]  grand_op_o,
    output logic [2:0]  op_o,
    output logic [4:0]  rj_o,
    output logic [4:0]  rk_o,
    output logic [4:0]  rd_o,
    output logic        wen_o,
    output logic        use_imm_o,
    output logic [31:0] imm_o,
    output logic [31:0] pc_o
`ifdef D_DECODE_ILLEGAL_FLAG_EN
    ,
    output logic        illegal_o
`endif
);

    if (SKID_DEPTH != 2) begin : g_skid_depth_check
        $error("d_alu_decoder: SKID_DEPTH must be 2");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e   state_q;
    alu_dec_t dec;
    alu_dec_t head_q;
    alu_dec_t skid_q;
    logic     out_valid_q;
    logic     in_ready_q;
    logic     in_fire;
    logic     out_fire;

    d_alu_dec_comb u_dec_comb (
        .inst (inst_i),
        .pc   (pc_i),
        .dec  (dec)
    );

    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = out_valid_q & out_ready_i;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset as well because their
            // contents drive the bundle outputs, which must read 0 after reset.
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush_i) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        head_q      <= dec;
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        head_q <= dec;
                    end else if (in_fire) begin
                        skid_q     <= dec;
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so no in-fire can coincide.
                    if (out_fire) begin
                        head_q     <= skid_q;
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign grand_op_o  = head_q.grand_op;
    assign op_o        = head_q.op;
    assign rj_o        = head_q.rj;
    assign rk_o        = head_q.rk;
    assign rd_o        = head_q.rd;
    assign wen_o       = head_q.wen;
    assign use_imm_o   = head_q.use_imm;
    assign imm_o       = head_q.imm;
    assign pc_o        = head_q.pc;

`ifdef D_DECODE_ILLEGAL_FLAG_EN
    assign illegal_o = head_q.illegal;
`else
    logic unused_illegal;
    assign unused_illegal = head_q.illegal;
`endif

endmodule

// File: tb/tb_d_alu_decoder.sv
module tb_d_alu_decoder;
    import d_alu_decoder_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] inst_i;
    logic [31:0] pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [2:0]  grand_op_o;
    logic [2:0]  op_o;
    logic [4:0]  rj_o;
    logic [4:0]  rk_o;
    logic [4:0]  rd_o;
    logic        wen_o;
    logic        use_imm_o;
    logic [31:0] imm_o;
    logic [31:0] pc_o;
`ifdef D_DECODE_ILLEGAL_FLAG_EN
    logic        illegal_o;
`endif

    int checks;
    int failures;

    d_alu_decoder #(.SKID_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .inst_i      (inst_i),
        .pc_i        (pc_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .grand_op_o  (grand_op_o),
        .op_o        (op_o),
        .rj_o        (rj_o),
        .rk_o        (rk_o),
        .rd_o        (rd_o),
        .wen_o       (wen_o),
        .use_imm_o   (use_imm_o),
        .imm_o       (imm_o),
        .pc_o        (pc_o)
`ifdef D_DECODE_ILLEGAL_FLAG_EN
        ,
        .illegal_o   (illegal_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // One instruction through an empty decoder with out_ready high; returns
    // at the negedge where the bundle is on the outputs.
    task automatic issue_one(input logic [31:0] inst, input logic [31:0] pc);
        @(negedge clk);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        inst_i      = inst;
        pc_i        = pc;
        @(negedge clk);
        in_valid_i  = 1'b0;
    endtask

    // Two instructions with out_ready low; returns with head + skid occupied.
    task automatic fill_full();
        @(negedge clk);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        inst_i      = 32'h00100C41;
        pc_i        = 32'h0000_0200;
        @(negedge clk);
        inst_i      = 32'h001120E6;
        pc_i        = 32'h0000_0204;
        @(negedge clk);
        in_valid_i  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid_o, in_ready_o} !== 2'b01) begin
            failures++;
            $display("FAIL reset_handshake: got valid/ready %b expected 01", {out_valid_o, in_ready_o});
        end
        checks++;
        if ({grand_op_o, op_o, wen_o, use_imm_o, imm_o, pc_o} !== 72'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0", {grand_op_o, op_o, wen_o, use_imm_o, imm_o, pc_o});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        issue_one(32'h02BFFC85, 32'h1C00_0010);
        checks++;
        if (out_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL addi_valid: got %b expected 1", out_valid_o);
        end
        checks++;
        if ({grand_op_o, op_o, rj_o, rd_o, use_imm_o, wen_o, imm_o} !==
            {GRAND_OP_INT, INT_ADD, 5'd4, 5'd5, 1'b1, 1'b1, 32'hFFFF_FFFF}) begin
            failures++;
            $display("FAIL addi_bundle: got %h expected %h", {grand_op_o, op_o, rj_o, rd_o, use_imm_o, wen_o, imm_o},
                     {GRAND_OP_INT, INT_ADD, 5'd4, 5'd5, 1'b1, 1'b1, 32'hFFFF_FFFF});
        end
`ifdef D_DECODE_ILLEGAL_FLAG_EN
        checks++;
        if (illegal_o !== 1'b0) begin
            failures++;
            $display("FAIL addi_illegal: got %b expected 0", illegal_o);
        end
`endif
    endtask

    task automatic test_lu12i();
        // inst[24:5] of 0x14ACF1E3 is 0x5678F.
        issue_one(32'h14ACF1E3, 32'h1C00_0014);
        checks++;
        if ({grand_op_o, op_o, rd_o, use_imm_o, wen_o, imm_o} !==
            {GRAND_OP_LI, LI_LUI, 5'd3, 1'b1, 1'b1, 32'h0005_678F}) begin
            failures++;
            $display("FAIL lu12i_bundle: got %h expected %h", {grand_op_o, op_o, rd_o, use_imm_o, wen_o, imm_o},
                     {GRAND_OP_LI, LI_LUI, 5'd3, 1'b1, 1'b1, 32'h0005_678F});
        end
    endtask

    task automatic test_bne();
        issue_one(32'h5C000C85, 32'h1C00_0000);
        checks++;
        if ({grand_op_o, op_o, rj_o, rk_o, wen_o, use_imm_o, imm_o} !==
            {GRAND_OP_COM, COM_NE, 5'd4, 5'd5, 1'b0, 1'b0, 32'h0000_000C}) begin
            failures++;
            $display("FAIL bne_bundle: got %h expected %h", {grand_op_o, op_o, rj_o, rk_o, wen_o, use_imm_o, imm_o},
                     {GRAND_OP_COM, COM_NE, 5'd4, 5'd5, 1'b0, 1'b0, 32'h0000_000C});
        end
        checks++;
        if (pc_o !== 32'h1C00_0000) begin
            failures++;
            $display("FAIL bne_pc: got %h expected 1c000000", pc_o);
        end
    endtask

    task automatic test_boundaries();
        // beq with offs16 = 0xFFFF: offset -4
        issue_one(32'h5BFFFC22, 32'h0000_0300);
        checks++;
        if ({grand_op_o, op_o, rj_o, rk_o, imm_o} !== {GRAND_OP_COM, COM_EQ, 5'd1, 5'd2, 32'hFFFF_FFFC}) begin
            failures++;
            $display("FAIL beq_neg_imm: got %h expected %h", {grand_op_o, op_o, rj_o, rk_o, imm_o},
                     {GRAND_OP_COM, COM_EQ, 5'd1, 5'd2, 32'hFFFF_FFFC});
        end
        // andi with imm12 = 0x800 must zero-extend
        issue_one(32'h03600022, 32'h0000_0304);
        checks++;
        if ({grand_op_o, op_o, use_imm_o, imm_o} !== {GRAND_OP_BW, BW_AND, 1'b1, 32'h0000_0800}) begin
            failures++;
            $display("FAIL andi_zext: got %h expected %h", {grand_op_o, op_o, use_imm_o, imm_o},
                     {GRAND_OP_BW, BW_AND, 1'b1, 32'h0000_0800});
        end
        // add.w r0, r2, r3: no write to r0
        issue_one(32'h00100C40, 32'h0000_0308);
        checks++;
        if ({grand_op_o, op_o, rk_o, wen_o} !== {GRAND_OP_INT, INT_ADD, 5'd3, 1'b0}) begin
            failures++;
            $display("FAIL add_rd0_wen: got %h expected %h", {grand_op_o, op_o, rk_o, wen_o},
                     {GRAND_OP_INT, INT_ADD, 5'd3, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        // A = add.w r1,r2,r3  B = sub.w r6,r7,r8  C = xor r9,r10,r11
        @(negedge clk);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        inst_i      = 32'h00100C41;
        pc_i        = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_c1: got %b expected 1", in_ready_o);
        end
        inst_i = 32'h001120E6;
        pc_i   = 32'h0000_0104;
        @(negedge clk);
        inst_i = 32'h0015AD49;
        pc_i   = 32'h0000_0108;
        checks++;
        if ({in_ready_o, out_valid_o, pc_o} !== {1'b0, 1'b1, 32'h0000_0100}) begin
            failures++;
            $display("FAIL bp_full: got ready/valid/pc %h expected %h", {in_ready_o, out_valid_o, pc_o},
                     {1'b0, 1'b1, 32'h0000_0100});
        end
        @(negedge clk);
        checks++;
        if ({in_ready_o, pc_o} !== {1'b0, 32'h0000_0100}) begin
            failures++;
            $display("FAIL bp_hold: got ready/pc %h expected %h", {in_ready_o, pc_o}, {1'b0, 32'h0000_0100});
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready_o, grand_op_o, op_o, rd_o, rk_o, pc_o} !==
            {1'b1, GRAND_OP_INT, INT_SUB, 5'd6, 5'd8, 32'h0000_0104}) begin
            failures++;
            $display("FAIL bp_drain_b: got %h expected %h", {in_ready_o, grand_op_o, op_o, rd_o, rk_o, pc_o},
                     {1'b1, GRAND_OP_INT, INT_SUB, 5'd6, 5'd8, 32'h0000_0104});
        end
        @(negedge clk);
        in_valid_i = 1'b0;
        checks++;
        if ({out_valid_o, grand_op_o, op_o, rj_o, pc_o} !== {1'b1, GRAND_OP_BW, BW_XOR, 5'd10, 32'h0000_0108}) begin
            failures++;
            $display("FAIL bp_drain_c: got %h expected %h", {out_valid_o, grand_op_o, op_o, rj_o, pc_o},
                     {1'b1, GRAND_OP_BW, BW_XOR, 5'd10, 32'h0000_0108});
        end
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty: got valid %b expected 0", out_valid_o);
        end
    endtask

    task automatic test_flush();
        fill_full();
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        inst_i     = 32'h0015AD49;
        pc_i       = 32'h0000_0208;
        @(negedge clk);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        checks++;
        if ({out_valid_o, in_ready_o} !== 2'b01) begin
            failures++;
            $display("FAIL flush_full: got valid/ready %b expected 01", {out_valid_o, in_ready_o});
        end
        // Flush in ONE state with a valid input: the input must be dropped.
        in_valid_i = 1'b1;
        inst_i     = 32'h00100C41;
        pc_i       = 32'h0000_0210;
        @(negedge clk);
        flush_i    = 1'b1;
        inst_i     = 32'h001120E6;
        pc_i       = 32'h0000_0214;
        @(negedge clk);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid_o, in_ready_o} !== 2'b01) begin
            failures++;
            $display("FAIL flush_drop_input: got valid/ready %b expected 01", {out_valid_o, in_ready_o});
        end
        // slli.w r4, r5, 7 afterwards flows normally
        issue_one(32'h00409CA4, 32'h0000_0220);
        checks++;
        if ({out_valid_o, grand_op_o, op_o, rj_o, rd_o, use_imm_o, wen_o, imm_o, pc_o} !==
            {1'b1, GRAND_OP_SFT, SFT_SLL, 5'd5, 5'd4, 1'b1, 1'b1, 32'h0000_0007, 32'h0000_0220}) begin
            failures++;
            $display("FAIL flush_after: got %h expected %h",
                     {out_valid_o, grand_op_o, op_o, rj_o, rd_o, use_imm_o, wen_o, imm_o, pc_o},
                     {1'b1, GRAND_OP_SFT, SFT_SLL, 5'd5, 5'd4, 1'b1, 1'b1, 32'h0000_0007, 32'h0000_0220});
        end
    endtask

    task automatic test_illegal();
        issue_one(32'hFFFF_FFFF, 32'h0000_0400);
        checks++;
        if ({out_valid_o, grand_op_o, wen_o, use_imm_o, imm_o} !== {1'b1, 3'd0, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL illegal_nop: got %h expected %h", {out_valid_o, grand_op_o, wen_o, use_imm_o, imm_o},
                     {1'b1, 3'd0, 1'b0, 1'b0, 32'h0});
        end
`ifdef D_DECODE_ILLEGAL_FLAG_EN
        checks++;
        if (illegal_o !== 1'b1) begin
            failures++;
            $display("FAIL illegal_flag: got %b expected 1", illegal_o);
        end
`endif
    endtask

    task automatic test_reset_mid_full();
        fill_full();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid_o, in_ready_o, grand_op_o, pc_o} !== {1'b0, 1'b1, 3'd0, 32'h0}) begin
            failures++;
            $display("FAIL reset_async: got %h expected %h", {out_valid_o, in_ready_o, grand_op_o, pc_o},
                     {1'b0, 1'b1, 3'd0, 32'h0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid_o, in_ready_o} !== 2'b01) begin
            failures++;
            $display("FAIL reset_release: got valid/ready %b expected 01", {out_valid_o, in_ready_o});
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        inst_i      = 32'h0;
        pc_i        = 32'h0;

        test_reset();
        test_addi();
        test_lu12i();
        test_bne();
        test_boundaries();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_reset_mid_full();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
